// File: rtl/regdemo_pkg.sv
// Shared types, constants and pattern helpers for the register-file demo generator.
package regdemo_pkg;

  typedef enum logic [1:0] {
    ModeRotate = 2'b00,
    ModeRandom = 2'b01,
    ModeStep   = 2'b10,
    ModeFreeze = 2'b11
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 0x01 in every byte lane of a dw-bit word (dw <= 64).
  function automatic logic [63:0] inc_pattern(int unsigned dw);
    logic [63:0] p;
    p = '0;
    for (int unsigned b = 0; b < dw / 8; b++) begin
      p[b*8 +: 8] = 8'h01;
    end
    return p;
  endfunction

  // idx * {0x1 in every nibble}; caller truncates to its width.
  function automatic logic [63:0] reset_pattern(int unsigned idx, int unsigned dw);
    logic [63:0] nib;
    nib = '0;
    for (int unsigned n = 0; n < dw / 4; n++) begin
      nib[n*4 +: 4] = 4'h1;
    end
    return nib * 64'(idx);
  endfunction

endpackage

// File: rtl/regdemo_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
module regdemo_lfsr16
  import regdemo_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = ^(r_state & LFSR_TAPS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LFSR_SEED;
    end else if (i_en) begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/regfile_demo_gen.sv
// Demo register file that self-updates on a timer or push-button and highlights the last write.
// Build option: define REGDEMO_LFSR_EN to include the RANDOM mode and its LFSR.
module regfile_demo_gen
  import regdemo_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PERIOD_LOG2 = 20,
  parameter int unsigned HOLD_CYCLES = 2**22,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 mode,
  input  logic                       step,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        changed_mask,
  output logic [IDX_W-1:0]           last_idx,
  output logic                       update_valid
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PERIOD_LOG2-1:0] TICK_ONE    = PERIOD_LOG2'(1);
  localparam logic [PERIOD_LOG2-1:0] TICK_MAX    = '1;
  localparam logic [PERIOD_LOG2-1:0] TICK_PRE    = TICK_MAX - TICK_ONE;
  localparam logic [IDX_W-1:0]       IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]       ROT_LAST    = IDX_W'(NUM_REGS - 1);
  localparam logic [HOLD_W-1:0]      HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]      HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_REGS-1:0]    MASK_ONE    = NUM_REGS'(1);
  localparam logic [DATA_W-1:0]      INC         = DATA_W'(inc_pattern(DATA_W));

  mode_e                  w_mode;
  logic [PERIOD_LOG2-1:0] r_tick;
  logic [PERIOD_LOG2-1:0] w_tick_d;
  logic [IDX_W-1:0]       r_rot_idx;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_step_prev;
  logic                   w_step_rise;
  logic                   w_sched;
  logic                   r_upd;
  logic [HOLD_W-1:0]      r_hold;
  logic [NUM_REGS-1:0]    r_mask;
  logic [IDX_W-1:0]       r_last_idx;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic [IDX_W-1:0]       w_wr_idx;
  logic [DATA_W-1:0]      w_wr_data;
  logic                   w_rot_adv;

  assign w_mode      = mode_e'(mode);
  assign w_step_rise = r_sync2 & ~r_step_prev;

  // An update is scheduled one edge ahead so update_valid is high in the all-ones tick
  // cycle and the write lands on the edge that ends it.
  always_comb begin
    w_tick_d = r_tick;
    w_sched  = 1'b0;
    case (w_mode)
      ModeRotate, ModeRandom: begin
        w_tick_d = r_tick + TICK_ONE;
        w_sched  = (r_tick == TICK_PRE);
      end
      ModeStep: begin
        w_tick_d = '0;
        w_sched  = w_step_rise;
      end
      default: ;
    endcase
  end

`ifdef REGDEMO_LFSR_EN
  localparam logic [IDX_W:0] NUM_REGS_X = (IDX_W+1)'(NUM_REGS);

  logic [15:0]       w_lfsr;
  logic [IDX_W:0]    w_rand_raw;
  logic [IDX_W-1:0]  w_rand_idx;
  logic [DATA_W-1:0] w_lfsr_rep;
  logic              r_upd_rand;

  regdemo_lfsr16 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (r_upd & r_upd_rand),
    .o_state (w_lfsr)
  );

  always_comb begin
    w_lfsr_rep = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      w_lfsr_rep[b] = w_lfsr[b % 16];
    end
    w_rand_raw = {1'b0, w_lfsr[IDX_W-1:0]};
    w_rand_idx = (w_rand_raw >= NUM_REGS_X) ? IDX_W'(w_rand_raw - NUM_REGS_X)
                                            : IDX_W'(w_rand_raw);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_upd_rand <= 1'b0;
    end else begin
      r_upd_rand <= w_sched && (w_mode == ModeRandom);
    end
  end

  assign w_wr_idx  = r_upd_rand ? w_rand_idx : r_rot_idx;
  assign w_wr_data = r_upd_rand ? (r_regs[w_rand_idx] ^ w_lfsr_rep) : (r_regs[r_rot_idx] + INC);
  assign w_rot_adv = ~r_upd_rand;
`else
  assign w_wr_idx  = r_rot_idx;
  assign w_wr_data = r_regs[r_rot_idx] + INC;
  assign w_rot_adv = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick      <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_step_prev <= 1'b0;
      r_upd       <= 1'b0;
    end else begin
      r_tick      <= w_tick_d;
      r_sync1     <= step;
      r_sync2     <= r_sync1;
      r_step_prev <= r_sync2;
      r_upd       <= w_sched;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rot_idx <= '0;
    end else if (r_upd && w_rot_adv) begin
      r_rot_idx <= (r_rot_idx == ROT_LAST) ? '0 : r_rot_idx + IDX_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(reset_pattern(i, DATA_W));
      end
    end else if (r_upd) begin
      r_regs[w_wr_idx] <= w_wr_data;
    end
  end

  // Highlight countdown runs in every mode, including FREEZE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '0;
      r_hold     <= '0;
      r_last_idx <= '0;
    end else if (r_upd) begin
      r_mask     <= MASK_ONE << w_wr_idx;
      r_hold     <= HOLD_RELOAD;
      r_last_idx <= w_wr_idx;
    end else if (r_mask != '0) begin
      if (r_hold == '0) begin
        r_mask <= '0;
      end else begin
        r_hold <= r_hold - HOLD_ONE;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign changed_mask = r_mask;
  assign last_idx     = r_last_idx;
  assign update_valid = r_upd;

endmodule

// File: doc/regfile_demo_gen.md
REGFILE_DEMO_GEN -- requirements
Module: regfile_demo_gen

Interface
REQ-001 Parameter NUM_REGS, default 32: number of demo registers, legal range 2..64.
REQ-002 Parameter DATA_W, default 32: register width, a multiple of 8, legal range 8..64.
REQ-003 Parameter PERIOD_LOG2, default 20: an automatic update occurs every 2**PERIOD_LOG2 cycles.
REQ-004 Parameter HOLD_CYCLES, default 2**22: number of cycles a change highlight stays asserted.
REQ-005 Port clock, input, 1 bit: 50 MHz system clock; the only clock.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port mode, input, 2 bits: 00 ROTATE, 01 RANDOM, 10 STEP, 11 FREEZE.
REQ-008 Port step, input, 1 bit: asynchronous push-button; each press requests one update in STEP mode.
REQ-009 Port regs_flat, output, NUM_REGS*DATA_W bits: register i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port changed_mask, output, NUM_REGS bits: one-hot highlight for the last-updated register, or all zeros.
REQ-011 Port last_idx, output, clog2(NUM_REGS) bits: index of the most recent update.
REQ-012 Port update_valid, output, 1 bit: single-cycle pulse coincident with each register write.

Function
REQ-013 Tick counter SHALL be PERIOD_LOG2 bits wide, increment every cycle in ROTATE and RANDOM, and wrap from all-ones to 0.
REQ-014 In ROTATE and RANDOM, update_valid SHALL pulse in the cycle the tick is all-ones, and the register write SHALL take effect at that clock edge.
REQ-015 ROTATE: regs[rot_idx] += INC, where INC = {DATA_W/8{8'h01}}, modulo 2**DATA_W; rot_idx SHALL wrap from NUM_REGS-1 to 0, including for non-power-of-two NUM_REGS.
REQ-016 RANDOM: idx = low clog2(NUM_REGS) LFSR bits, minus NUM_REGS if that value is >= NUM_REGS; regs[idx] ^= LFSR replicated/truncated to DATA_W bits; the LFSR SHALL advance once per update; rot_idx SHALL be unchanged.
REQ-017 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, never all-zero.
REQ-018 STEP: tick SHALL be held at 0; step is double-flop synchronised, then rising-edge detected; each detected edge SHALL perform exactly one ROTATE update; latency from the step pin edge to update_valid is 3 cycles.
REQ-019 FREEZE: tick SHALL be held; no updates; regs SHALL be held; the highlight countdown SHALL continue.
REQ-020 A mode change SHALL take effect from the next cycle; tick SHALL NOT be cleared on a mode change except when entering STEP.
REQ-021 On each update, changed_mask SHALL become one-hot at the written index, last_idx SHALL be set to that index, and the hold counter SHALL reload to HOLD_CYCLES-1; a new update during a hold SHALL replace the mask.
REQ-022 The hold counter SHALL decrement to 0, after which changed_mask SHALL be cleared; HOLD_CYCLES=1 SHALL give a one-cycle highlight.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While reset_n=0: regs[i] = i * {DATA_W/4{4'h1}} truncated to DATA_W bits; tick=0, rot_idx=0, LFSR=seed, changed_mask=0, last_idx=0, update_valid=0, hold counter=0, synchroniser and edge flops=0.
REQ-025 Reset asserted mid-hold or mid-period SHALL abort immediately; the first update after release SHALL occur 2**PERIOD_LOG2 cycles later.

Configuration
REQ-026 Macro REGDEMO_LFSR_EN: when defined, the RANDOM mode and the LFSR are present; when undefined, no LFSR logic is built and mode 01 behaves exactly as ROTATE.

Structure
REQ-027 Package regdemo_pkg SHALL hold the mode_e enum, LFSR_SEED, LFSR taps and the INC/reset-pattern helper functions.
REQ-028 Sub-module regdemo_lfsr16 (enable, state out) SHALL implement the LFSR; it is instantiated only under REGDEMO_LFSR_EN.

Verification
REQ-029 NUM_REGS=32, DATA_W=32, PERIOD_LOG2=4, ROTATE -> update_valid at cycles 15, 31, ...; regs[0]=0x01010101 after the first update; changed_mask=0x1, then 0x2.
REQ-030 NUM_REGS=5, PERIOD_LOG2=2, ROTATE, 6 updates -> rot_idx sequence 0,1,2,3,4,0; regs[0] = 2*INC added to its reset value.
REQ-031 STEP mode, pulse step for 2 cycles -> exactly one update_valid, 3 cycles after the edge; a held step produces no repeat.
REQ-032 HOLD_CYCLES=8, ROTATE, then FREEZE right after an update -> changed_mask clears after 8 cycles, regs unchanged, no update_valid.
REQ-033 With REGDEMO_LFSR_EN, RANDOM with NUM_REGS=20 -> every last_idx < 20 and first XOR operand 0xACE1ACE1; without the macro, behaviour identical to REQ-029.
REQ-034 Assert reset_n low mid-hold -> all outputs return to reset values asynchronously, without waiting for a clock edge.
